// File: rtl/cp0_unit.sv
// Coprocessor-0 SR/Cause/EPC/PRId file with exception/interrupt arbitration; optional CP0_EPC_BYPASS_EN forwards mtc0 EPC data onto epc.
// Latency: dout/req combinational; register writes visible the cycle after the edge; Cause.IP lags hwint by one cycle.
// Backpressure: none; req is a flush request the pipeline must honour on the same edge.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h0000_4D49
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic        eret,
  input  logic [5:0]  hwint,
  output logic [31:0] dout,
  output logic [31:0] epc,
  output logic        req
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;

  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_next;

  assign int_req  = (|(hwint & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req  = exc_valid & ~sr_exl;
  // state is undefined before the first reset edge, so hold req low throughout reset
  assign req      = (int_req | exc_req) & ~reset;
  assign epc_next = bd ? (pc - 32'd4) : pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc_q     <= '0;
    end else begin
      cause_ip <= hwint;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bd;
        cause_exc <= int_req ? 5'd0 : exc_code;
        epc_q     <= {epc_next[31:2], 2'b00};
      end else begin
        if (we && a2 == 5'd12) begin
          sr_im  <= din[15:10];
          sr_exl <= din[1];
          sr_ie  <= din[0];
        end
        if (we && a2 == 5'd14) begin
          epc_q <= {din[31:2], 2'b00};
        end
        // placed last so an eret clear overrides a same-edge EXL write
        if (eret) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    dout = '0;
    case (a1)
      5'd12:   dout = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
      5'd13:   dout = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
      5'd14:   dout = epc_q;
      5'd15:   dout = PRID;
      default: dout = '0;
    endcase
  end

`ifdef CP0_EPC_BYPASS_EN
  assign epc = (we && a2 == 5'd14 && !req && !reset) ? {din[31:2], 2'b00} : epc_q;
`else
  assign epc = epc_q;
`endif

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: stimulus queues expected outputs, a negedge monitor pops and compares them.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h0000_4D49;
  localparam logic [1:0] S_DOUT = 2'd0;
  localparam logic [1:0] S_EPC  = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  a1, a2, exc_code;
  logic [31:0] din, pc;
  logic        we, bd, exc_valid, eret;
  logic [5:0]  hwint;
  logic [31:0] dout, epc;
  logic        req;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] exp;
    logic [95:0] tag;
  } chk_t;

  chk_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  cp0_unit #(.PRID(PRID)) dut (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .din(din), .we(we),
    .pc(pc), .bd(bd), .exc_valid(exc_valid), .exc_code(exc_code),
    .eret(eret), .hwint(hwint), .dout(dout), .epc(epc), .req(req)
  );

  always #5 clk = ~clk;

  // monitor: checks everything queued during the current cycle against live outputs
  always @(negedge clk) begin
    chk_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        S_DOUT:  act = dout;
        S_EPC:   act = epc;
        default: act = {31'b0, req};
      endcase
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %0s: got %08h expected %08h", e.tag, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [1:0] sel, input logic [31:0] val, input logic [95:0] tag);
    sb.push_back('{sel: sel, exp: val, tag: tag});
  endtask

  task automatic rd(input logic [4:0] r, input logic [31:0] val, input logic [95:0] tag);
    a1 = r;
    chk(S_DOUT, val, tag);
    tick();
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    we = 1'b1; a2 = r; din = d;
    tick();
    we = 1'b0; a2 = '0; din = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; a1 = '0; a2 = 5'd14; din = 32'hFFFF_FFFF; we = 1'b1;
    pc = 32'h0000_1000; bd = 1'b0; exc_valid = 1'b1; exc_code = 5'd10;
    eret = 1'b0; hwint = '0;

    // in reset with noisy inputs
    tick();
    chk(S_EPC, 32'h0, "rst_epc");
    chk(S_REQ, 32'h0, "rst_req");
    tick();
    reset = 1'b0; we = 1'b0; a2 = '0; din = '0; exc_valid = 1'b0; exc_code = '0; pc = '0;

    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epcreg");
    rd(5'd15, PRID,  "rst_prid");
    rd(5'd3,  32'h0, "rd_other");

    // writable-field masks
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, 32'h0000_FC03, "sr_mask");
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 32'h0, "cause_ro");
    mtc0(5'd12, 32'h0);

    // interrupt from a delay slot
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'b000001; pc = 32'h0000_3008; bd = 1'b1;
    chk(S_REQ, 32'h1, "int_req");
    #1;
    vectors++;
    if (req !== 1'b1) begin
        miscompares++;
        $display("FAIL int_req_direct: got %0b expected 1", req);
    end
    tick();
    bd = 1'b0; pc = '0;
    chk(S_REQ, 32'h0, "exl_mask");
    chk(S_EPC, 32'h0000_3004, "int_epc");
    rd(5'd14, 32'h0000_3004, "int_epcreg");
    rd(5'd13, 32'h8000_0400, "int_cause");
    rd(5'd12, 32'h0000_0403, "int_sr");

    // pending interrupt becomes visible once eret clears EXL
    eret = 1'b1;
    chk(S_REQ, 32'h0, "req_pre_eret");
    tick();
    eret = 1'b0; pc = 32'h0000_3100;
    chk(S_REQ, 32'h1, "req_post_eret");
    a1 = 5'd12;
    chk(S_DOUT, 32'h0000_0401, "sr_post_eret");
    tick();
    pc = '0;
    rd(5'd14, 32'h0000_3100, "int2_epc");
    rd(5'd13, 32'h0000_0400, "int2_cause");
    hwint = '0; eret = 1'b1;
    tick();
    eret = 1'b0;
    rd(5'd12, 32'h0000_0401, "eret_clr");
    mtc0(5'd12, 32'h0);

    // exception with a concurrent mtc0 EPC that must be dropped
    exc_valid = 1'b1; exc_code = 5'd12; pc = 32'h0000_3010;
    we = 1'b1; a2 = 5'd14; din = 32'h0000_1234;
    chk(S_REQ, 32'h1, "exc_req");
    #1;
    vectors++;
    if (req !== 1'b1) begin
        miscompares++;
        $display("FAIL exc_req_direct: got %0b expected 1", req);
    end
    tick();
    exc_valid = 1'b0; exc_code = '0; pc = '0; we = 1'b0; a2 = '0; din = '0;
    chk(S_EPC, 32'h0000_3010, "exc_epc");
    rd(5'd14, 32'h0000_3010, "exc_epcreg");
    rd(5'd13, 32'h0000_0030, "exc_cause");
    rd(5'd12, 32'h0000_0002, "exc_sr");

    // nested exception ignored
    exc_valid = 1'b1; exc_code = 5'd5; pc = 32'h0000_5000;
    chk(S_REQ, 32'h0, "nested_req");
    tick();
    exc_valid = 1'b0; exc_code = '0; pc = '0;
    rd(5'd14, 32'h0000_3010, "nested_epc");

    // forced eret + SR write: eret clear wins on EXL
    eret = 1'b1; we = 1'b1; a2 = 5'd12; din = 32'h0000_0403;
    tick();
    eret = 1'b0; we = 1'b0; a2 = '0; din = '0;
    rd(5'd12, 32'h0000_0401, "eret_vs_mtc0");

    // interrupt beats simultaneous exception
    hwint = 6'b000001; exc_valid = 1'b1; exc_code = 5'd4; pc = 32'h0000_3020;
    tick();
    exc_valid = 1'b0; exc_code = '0; pc = '0;
    chk(S_EPC, 32'h0000_3020, "prio_epc");
    rd(5'd13, 32'h0000_0400, "prio_cause");
    hwint = '0; eret = 1'b1;
    tick();
    eret = 1'b0;

    // EPC write forwarding
    we = 1'b1; a2 = 5'd14; din = 32'h0000_4003;
`ifdef CP0_EPC_BYPASS_EN
    chk(S_EPC, 32'h0000_4000, "epc_same");
`else
    chk(S_EPC, 32'h0000_3020, "epc_same");
`endif
    tick();
    we = 1'b0; a2 = '0; din = '0;
    chk(S_EPC, 32'h0000_4000, "epc_next");
    tick();

    // Cause.IP lags hwint by one cycle
    mtc0(5'd12, 32'h0);
    hwint = 6'b100000; a1 = 5'd13;
    chk(S_DOUT, 32'h0, "ip_late0");
    chk(S_REQ, 32'h0, "masked_req");
    #1;
    vectors++;
    if (req !== 1'b0) begin
        miscompares++;
        $display("FAIL masked_req_direct: got %0b expected 0", req);
    end
    tick();
    chk(S_DOUT, 32'h0000_8000, "ip_late1");
    tick();
    hwint = '0;
    tick();

    // reset in the middle of a handler
    exc_valid = 1'b1; exc_code = 5'd10; pc = 32'h0000_6000;
    tick();
    exc_valid = 1'b0; exc_code = '0; pc = '0;
    rd(5'd12, 32'h0000_0002, "pre_rst_sr");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk(S_EPC, 32'h0, "mid_rst_epc");
    rd(5'd12, 32'h0, "mid_rst_sr");
    rd(5'd15, PRID, "mid_rst_prid");
    #1;
    vectors++;
    if (dout !== PRID) begin
        miscompares++;
        $display("FAIL prid_direct: got %08h expected %08h", dout, PRID);
    end

    tick();
    tick();
    while (sb.size() > 0) begin
      chk_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %0s: got no sample expected %08h", e.tag, e.exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
